// File: rtl/fir_decimate_pkg.sv
// Shared constants, state encoding and fixed-point helper for the decimating FIR.
// Q-format coefficients carry QUANT_BITS fractional bits.
package fir_decimate_pkg;

  localparam int QUANT_BITS = 10;
  localparam int FIR_DEFAULT_NUM_TAPS = 32;

  typedef enum logic [1:0] {
    S_LOAD,
    S_MAC,
    S_OUT
  } fir_state_t;

  // Symmetric low-pass window, Q10.
  localparam logic signed [31:0] FIR_DEFAULT_COEFFS [FIR_DEFAULT_NUM_TAPS] = '{
    32'sd4,  32'sd6,  32'sd9,  32'sd13, 32'sd18, 32'sd24, 32'sd31, 32'sd38,
    32'sd45, 32'sd52, 32'sd58, 32'sd63, 32'sd67, 32'sd70, 32'sd72, 32'sd73,
    32'sd73, 32'sd72, 32'sd70, 32'sd67, 32'sd63, 32'sd58, 32'sd52, 32'sd45,
    32'sd38, 32'sd31, 32'sd24, 32'sd18, 32'sd13, 32'sd9,  32'sd6,  32'sd4
  };

  // Divide by 2^QUANT_BITS rounding toward zero, then keep the low 32 bits.
  // Negative values get a bias of (2^QUANT_BITS - 1) so the arithmetic shift
  // truncates toward zero instead of toward minus infinity.
  function automatic logic signed [31:0] dequantize_i(input logic signed [63:0] prod);
    logic signed [63:0] bias;
    logic signed [63:0] quot;
    bias = prod[63] ? ((64'sd1 <<< QUANT_BITS) - 64'sd1) : 64'sd0;
    quot = (prod + bias) >>> QUANT_BITS;
    return 32'(quot);
  endfunction

endpackage

// File: rtl/fir_decimate.sv
// Decimating real FIR: loads DECIM samples from a show-ahead FIFO, then runs one
// multiply-accumulate per clock over all taps and pushes one result downstream.
//
// state  | meaning
// S_LOAD | pop input samples into the history until DECIM have arrived
// S_MAC  | accumulate COEFFS[k] * x[k], one tap per cycle
// S_OUT  | present the accumulator to the output FIFO, wait while it is full
module fir_decimate
  import fir_decimate_pkg::*;
#(
  parameter int NUM_TAPS = 32,
  parameter int DECIM    = 8,
  parameter logic signed [31:0] COEFFS [NUM_TAPS] = FIR_DEFAULT_COEFFS
) (
  input  logic               clock,
  input  logic               reset,
  output logic               in_rd_en,
  input  logic               in_empty,
  input  logic signed [31:0] in_dout,
  output logic               out_wr_en,
  input  logic               out_full,
  output logic signed [31:0] out_din
);

  localparam int KW = $clog2(NUM_TAPS);
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_TAPS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

  fir_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [KW-1:0]      k_q, k_d;
  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] x_q [NUM_TAPS];
  logic               shift_en;
  logic signed [63:0] coef_ext;
  logic signed [63:0] samp_ext;
  logic signed [63:0] prod;
  logic signed [31:0] tap_term;

  assign coef_ext = {{32{COEFFS[k_q][31]}}, COEFFS[k_q]};
  assign samp_ext = {{32{x_q[k_q][31]}}, x_q[k_q]};
  assign prod     = coef_ext * samp_ext;
  assign tap_term = dequantize_i(prod);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    acc_d     = acc_q;
    shift_en  = 1'b0;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    out_din   = '0;

    unique case (state_q)
      S_LOAD: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          shift_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            acc_d   = '0;
            k_d     = '0;
            state_d = S_MAC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + tap_term;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_OUT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_OUT: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          out_din   = acc_q;
          state_d   = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase

    // Keep the FIFO strobes quiet for the whole reset pulse, not just after it.
    if (reset) begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
      out_din   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  // x_q[0] holds the newest sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) x_q[i] <= '0;
    end else if (shift_en) begin
      x_q[0] <= in_dout;
      for (int i = 1; i < NUM_TAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

endmodule

// File: doc/fir_decimate.md
Name: fir_decimate

Overview:
- Decimating real FIR filter; consumes the 32-bit Q-format sample stream that the two-input multiplier writes into its output FIFO.
- Every DECIM input samples produce one filtered output, written to a downstream FIFO. Typical downstream consumers are the audio deemphasis and the L+R/L−R combiner.
- Uses the same FIFO-style rd_en/empty and wr_en/full handshakes as the rest of the pipeline.
- Computes one multiply-accumulate per clock.

Parameters:
- NUM_TAPS, 32: number of filter taps; legal range 2..256.
- DECIM, 8: decimation factor; legal range 1..NUM_TAPS.
- COEFFS, GLOBALS::FIR_DEFAULT_COEFFS: array of NUM_TAPS signed 32-bit coefficients in Q(QUANT_BITS) format.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_rd_en  out  1  pops one sample from the input FIFO.
- in_empty  in  1  input FIFO empty.
- in_dout  in  32  signed input sample, valid while in_empty=0 (show-ahead FIFO).
- out_wr_en  out  1  pushes out_din into the output FIFO.
- out_full  in  1  output FIFO full.
- out_din  out  32  signed filtered sample.

Behaviour:
- Interface: reset is asynchronous and active-high; the clock is clock.
- Reset:
  - State goes to S_LOAD.
  - The shift register x[0..NUM_TAPS-1] is cleared to 0.
  - The load counter, tap index and accumulator are cleared to 0.
  - All outputs are 0.
  - Reset mid-operation discards any partial accumulation and all history.
- Outputs are combinational from the registered state:
  - in_rd_en and out_wr_en are never asserted in the same cycle.
  - out_din is 0 whenever out_wr_en=0.
- S_LOAD:
  - Condition: in_empty=0. Assert in_rd_en. Shift the history (x[i] <= x[i-1] for i≥1, x[0] <= in_dout). Increment the load counter.
  - When the counter reaches DECIM−1 on a pop: clear the counter, clear the accumulator, set the tap index to 0, go to S_MAC.
  - Condition: in_empty=1. Hold; no side effects.
- S_MAC:
  - One tap per cycle: acc <= acc + DEQUANTIZE(COEFFS[k] * x[k]).
  - After k = NUM_TAPS−1, go to S_OUT.
  - No FIFO activity in this state.
- S_OUT:
  - Condition: out_full=0. Assert out_wr_en with out_din = acc. Go to S_LOAD.
  - Condition: out_full=1. Hold acc; no writes and no reads. Back-pressure stalls input consumption.
- Arithmetic:
  - Each product is full 64-bit signed.
  - DEQUANTIZE is signed division by 2^QUANT_BITS with truncation toward zero. QUANT_BITS=10.
  - Each dequantized result is truncated to 32 bits.
  - The accumulator is 32-bit two's complement and wraps silently; there is no saturation.
- Latency: from the pop of the DECIM-th sample to out_wr_en is NUM_TAPS+1 cycles minimum.
- Throughput: one output per DECIM+NUM_TAPS+1 cycles when the FIFOs never stall.
- Startup: history starts at zeros. The first output is emitted after the first DECIM samples, with no warm-up suppression.
- Simultaneous events: in_empty toggling during S_MAC or S_OUT is ignored until the state returns to S_LOAD.

Decomposition:
- GLOBALS package (existing):
  - QUANT_BITS.
  - DEQUANTIZE_I function.
  - FIR_DEFAULT_COEFFS array constant.
  - state_t enum {S_LOAD, S_MAC, S_OUT}, named fir_state_t.
- Single module with no sub-module. The MAC datapath is small enough to stay inline.
- A fifo-wrapped top is left to the integration level.

Test Plan:
- Impulse:
  - Setup: NUM_TAPS=4, DECIM=1, COEFFS={1024,2048,-1024,512}.
  - Stimulus: samples 1024,0,0,0,0.
  - Required outputs: 1024, 2048, −1024, 512, 0.
- Decimation:
  - Setup: NUM_TAPS=4, DECIM=2, all COEFFS=1024.
  - Stimulus: samples 1..6 (raw integers).
  - Required outputs: exactly 3 outputs, values 3, 10, 18.
- Rounding toward zero:
  - Setup: NUM_TAPS=2, DECIM=1, COEFFS={1,1}.
  - Stimulus: samples −1023, then −1023.
  - Required outputs: 0, then 0, not −1; each tap truncates to 0.
- Back-pressure:
  - Stimulus: hold out_full=1 for 20 cycles once S_OUT is reached.
  - Required: out_wr_en=0, in_rd_en=0 and acc stable throughout. The single write occurs on the cycle after out_full drops, with the correct value.
- Input starvation:
  - Stimulus: in_empty toggles every other cycle.
  - Required: output values are identical to the non-stalled run, and in_rd_en is never asserted while in_empty=1.
- Mid-operation reset:
  - Stimulus: assert reset during S_MAC, then feed 1024,0,0,0 with the impulse configuration.
  - Required: outputs 1024, 2048, −1024, 512, with no trace of pre-reset history.
